// File: rtl/spi_xfer_arbiter_pkg.sv
// Shared types and constants for the two-client SPI transaction arbiter.
package spi_xfer_arbiter_pkg;

   localparam int LEN_W  = 7;
   localparam int BYTE_W = 8;
   localparam int NREQ   = 2;
   localparam int IDX_W  = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GRANT    = 3'd1,
      ST_LAUNCH   = 3'd2,
      ST_XFER     = 3'd3,
      ST_WAIT_END = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   function automatic logic [NREQ-1:0] client_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/spi_xfer_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: when both request, the client that did not win last time is chosen.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   input  logic       i_accept_idx,
   output logic       o_any,
   output logic       o_gnt_idx
);

   logic r_ptr;

   // Pointer holds the last accepted client; reset value 1 lets client 0 win the first contest.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= 1'b1;
      end else if (i_accept) begin
         r_ptr <= i_accept_idx;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   always_comb begin
      o_any = |i_req;
      if (i_req == 2'b11) begin
         o_gnt_idx = ~r_ptr;
      end else if (i_req[1]) begin
         o_gnt_idx = 1'b1;
      end else begin
         o_gnt_idx = 1'b0;
      end
   end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master between two clients: grants whole transactions round-robin,
// streams write bytes from and read bytes to the granted client, and reports completion or timeout.
module spi_xfer_arbiter
   import spi_xfer_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYC = 60000
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_valid_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic [NREQ*BYTE_W-1:0]   req_cmd_i,
   input  logic [NREQ*BYTE_W-1:0]   req_addr_i,
   input  logic [NREQ*LEN_W-1:0]    req_len_i,
   input  logic [NREQ*BYTE_W-1:0]   wr_data_i,
   output logic [NREQ-1:0]          wr_pop_o,
   output logic [BYTE_W-1:0]        rd_data_o,
   output logic [NREQ-1:0]          rd_valid_o,
   output logic [NREQ-1:0]          done_o,
   output logic                     err_o,
   output logic                     busy_o,
   output logic                     m_en_o,
   output logic [BYTE_W-1:0]        m_cmd_o,
   output logic [BYTE_W-1:0]        m_addr_o,
   output logic [BYTE_W-1:0]        m_wdata_o,
   output logic [LEN_W-1:0]         m_num_o,
   input  logic [BYTE_W-1:0]        m_rdata_i,
   input  logic                     m_rdone_i,
   input  logic                     m_csn_i
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   state_t              r_state;
   logic                r_gnt;
   logic [IDX_W-1:0]    r_idx;
   logic [TMO_W-1:0]    r_tmo;
   logic                r_wd_load;
   logic [NREQ-1:0]     r_req_ready;
   logic [NREQ-1:0]     r_rd_valid;
   logic [NREQ-1:0]     r_done;
   logic [BYTE_W-1:0]   r_rd_data;
   logic [BYTE_W-1:0]   r_m_cmd;
   logic [BYTE_W-1:0]   r_m_addr;
   logic [BYTE_W-1:0]   r_m_wdata;
   logic [LEN_W-1:0]    r_m_num;
   logic                r_err;
   logic                r_busy;
   logic                r_m_en;

   logic                w_arb_any;
   logic                w_arb_idx;
   logic [BYTE_W-1:0]   w_wd_sel;
   logic [BYTE_W-1:0]   w_cmd_sel;
   logic [BYTE_W-1:0]   w_addr_sel;
   logic [LEN_W-1:0]    w_len_sel;
   logic [IDX_W-1:0]    w_len_ext;
   logic                w_rdone_x;
   logic                w_pop_hit;
   logic                w_rd_hit;
   logic                w_last;
   logic                w_tmo_hit;

   rr_arb2 u_arb (
      .i_clk        (clk_i),
      .i_rst        (rst_i),
      .i_req        (req_valid_i),
      .i_accept     (r_state == ST_GRANT),
      .i_accept_idx (r_gnt),
      .o_any        (w_arb_any),
      .o_gnt_idx    (w_arb_idx)
   );

   assign w_wd_sel   = r_gnt ? wr_data_i[2*BYTE_W-1:BYTE_W]  : wr_data_i[BYTE_W-1:0];
   assign w_cmd_sel  = r_gnt ? req_cmd_i[2*BYTE_W-1:BYTE_W]  : req_cmd_i[BYTE_W-1:0];
   assign w_addr_sel = r_gnt ? req_addr_i[2*BYTE_W-1:BYTE_W] : req_addr_i[BYTE_W-1:0];
   assign w_len_sel  = r_gnt ? req_len_i[2*LEN_W-1:LEN_W]    : req_len_i[LEN_W-1:0];
   assign w_len_ext  = {1'b0, r_m_num};

   // idx 0 = cmd, 1 = addr, 2..len+1 = data; a pop at idx k feeds the byte for data slot k.
   assign w_rdone_x = (r_state == ST_XFER) && m_rdone_i;
   assign w_pop_hit = w_rdone_x && (r_idx >= 8'd1) && (r_idx <= w_len_ext);
   assign w_rd_hit  = w_rdone_x && (r_idx >= 8'd2);
   assign w_last    = w_rdone_x && (r_idx == (w_len_ext + 8'd1));
   assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

   assign wr_pop_o    = (w_pop_hit && !rst_i) ? client_onehot(r_gnt) : 2'b00;
   assign req_ready_o = r_req_ready;
   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign busy_o      = r_busy;
   assign m_en_o      = r_m_en;
   assign m_cmd_o     = r_m_cmd;
   assign m_addr_o    = r_m_addr;
   assign m_wdata_o   = r_m_wdata;
   assign m_num_o     = r_m_num;

   // Transaction FSM with byte index, timeout counter and all registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_gnt       <= 1'b0;
         r_idx       <= 8'd0;
         r_tmo       <= '0;
         r_wd_load   <= 1'b0;
         r_req_ready <= 2'b00;
         r_rd_valid  <= 2'b00;
         r_done      <= 2'b00;
         r_rd_data   <= 8'h00;
         r_m_cmd     <= 8'h00;
         r_m_addr    <= 8'h00;
         r_m_wdata   <= 8'h00;
         r_m_num     <= 7'd0;
         r_err       <= 1'b0;
         r_busy      <= 1'b0;
         r_m_en      <= 1'b0;
      end else begin
         r_req_ready <= 2'b00;
         r_rd_valid  <= 2'b00;
         r_done      <= 2'b00;
         r_m_en      <= 1'b0;
         r_wd_load   <= w_pop_hit;

         // The client FIFO head only advances after the pop edge, so reload one cycle late.
         if (r_wd_load) begin
            r_m_wdata <= w_wd_sel;
         end
         if (w_rd_hit) begin
            r_rd_data  <= m_rdata_i;
            r_rd_valid <= client_onehot(r_gnt);
         end

         case (r_state)
            ST_IDLE: begin
               r_err <= 1'b0;
               if (w_arb_any && m_csn_i) begin
                  r_gnt       <= w_arb_idx;
                  r_req_ready <= client_onehot(w_arb_idx);
                  r_busy      <= 1'b1;
                  r_state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_m_cmd   <= w_cmd_sel;
               r_m_addr  <= w_addr_sel;
               r_m_num   <= w_len_sel;
               r_m_wdata <= (w_len_sel == 7'd0) ? 8'h00 : w_wd_sel;
               r_m_en    <= 1'b1;
               r_state   <= ST_LAUNCH;
            end
            ST_LAUNCH: begin
               r_idx   <= 8'd0;
               r_tmo   <= TMO_W'(1);
               r_state <= ST_XFER;
            end
            ST_XFER: begin
               r_tmo <= r_tmo + TMO_W'(1);
               if (w_tmo_hit) begin
                  r_done  <= client_onehot(r_gnt);
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (m_rdone_i) begin
                  r_idx <= r_idx + 8'd1;
                  if (w_last) begin
                     r_state <= ST_WAIT_END;
                  end
               end
            end
            ST_WAIT_END: begin
               r_tmo <= r_tmo + TMO_W'(1);
               if (m_csn_i) begin
                  r_done  <= client_onehot(r_gnt);
                  r_state <= ST_DONE;
               end else if (w_tmo_hit) begin
                  r_done  <= client_onehot(r_gnt);
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: a model SPI master and client FIFOs drive the DUT,
// directed transactions queue their expected responses, and a monitor compares what the DUT presents.
module tb_spi_xfer_arbiter;

   localparam int TMO = 300;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [15:0] req_cmd_i;
   logic [15:0] req_addr_i;
   logic [13:0] req_len_i;
   logic [15:0] wr_data_i;
   logic [1:0]  wr_pop_o;
   logic [7:0]  rd_data_o;
   logic [1:0]  rd_valid_o;
   logic [1:0]  done_o;
   logic        err_o;
   logic        busy_o;
   logic        m_en_o;
   logic [7:0]  m_cmd_o;
   logic [7:0]  m_addr_o;
   logic [7:0]  m_wdata_o;
   logic [6:0]  m_num_o;
   logic [7:0]  m_rdata_i;
   logic        m_rdone_i;
   logic        m_csn_i;

   spi_xfer_arbiter #(.TIMEOUT_CYC(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
      .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .m_en_o(m_en_o), .m_cmd_o(m_cmd_o), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_num_o(m_num_o),
      .m_rdata_i(m_rdata_i), .m_rdone_i(m_rdone_i), .m_csn_i(m_csn_i)
   );

   initial forever #5 clk_i = ~clk_i;

   typedef struct { int cli; logic [7:0] cmd; logic [7:0] addr; int len; logic [7:0] wd0; } txn_t;
   typedef struct { int cli; logic [7:0] data; } rd_t;
   typedef struct { int cli; logic err; int dly; } done_t;

   txn_t  exp_txn[$];
   rd_t   exp_rd[$];
   done_t exp_done[$];
   logic [7:0] wfifo0[$], wfifo1[$], expwd0[$], expwd1[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cur_cli = 0;
   int launch_cyc = 0;
   int last_rdone_cyc = 0;
   int rd_seen = 0;
   bit hang = 1'b0;
   bit aborted = 1'b0;
   txn_t cur_t;

   function automatic logic [1:0] oh(input int c);
      return (c == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {14'd0, req_ready_o, wr_pop_o, rd_data_o, rd_valid_o, done_o, err_o, busy_o,
              m_en_o, m_cmd_o, m_addr_o, m_wdata_o, m_num_o};
   endfunction

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Client write FIFOs: show-ahead heads, advanced on the edge after a pop.
   logic [1:0] fifo_pop;
   initial begin
      wr_data_i = 16'h0000;
      forever begin
         @(negedge clk_i);
         fifo_pop = wr_pop_o;
         if (fifo_pop != 2'b00) begin
            chk("pop_client", {62'd0, fifo_pop}, {62'd0, oh(cur_cli)});
            if (fifo_pop[0]) chk("pop_c0_nonempty", 64'(wfifo0.size() != 0), 64'd1);
            if (fifo_pop[1]) chk("pop_c1_nonempty", 64'(wfifo1.size() != 0), 64'd1);
         end
         @(posedge clk_i);
         #1;
         if (fifo_pop[0] && wfifo0.size() != 0) void'(wfifo0.pop_front());
         if (fifo_pop[1] && wfifo1.size() != 0) void'(wfifo1.pop_front());
         wr_data_i[7:0]  = (wfifo0.size() != 0) ? wfifo0[0] : 8'h00;
         wr_data_i[15:8] = (wfifo1.size() != 0) ? wfifo1[0] : 8'h00;
      end
   end

   // Model SPI master: cmd, addr and m_num_o data bytes, one rdone every 4 cycles; rdata byte k = 0x40+k.
   int mst_n;
   int mst_cli;
   logic [7:0] mst_exp;
   initial begin
      m_csn_i = 1'b1;
      m_rdone_i = 1'b0;
      m_rdata_i = 8'h00;
      forever begin
         @(negedge clk_i);
         if (m_en_o) begin
            mst_n = int'(m_num_o);
            mst_cli = cur_cli;
            @(posedge clk_i);
            #1;
            m_csn_i = 1'b0;
            if (hang) begin
               while (hang) begin
                  @(posedge clk_i);
                  #1;
               end
            end else begin
               for (int k = 0; k < mst_n + 2; k++) begin
                  repeat (3) @(posedge clk_i);
                  #1;
                  m_rdone_i = 1'b1;
                  m_rdata_i = 8'h40 + 8'(k);
                  last_rdone_cyc = cyc;
                  if (k >= 1 && k <= mst_n && !aborted) begin
                     if (mst_cli == 0) begin
                        mst_exp = (expwd0.size() != 0) ? expwd0.pop_front() : 8'hxx;
                     end else begin
                        mst_exp = (expwd1.size() != 0) ? expwd1.pop_front() : 8'hxx;
                     end
                     chk("m_wdata_at_rdone", {56'd0, m_wdata_o}, {56'd0, mst_exp});
                  end
                  @(posedge clk_i);
                  #1;
                  m_rdone_i = 1'b0;
               end
            end
            repeat (2) @(posedge clk_i);
            #1;
            m_csn_i = 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a grant, launch, read byte or done.
   txn_t  mon_t;
   rd_t   mon_r;
   done_t mon_d;
   initial forever begin
      @(negedge clk_i);
      if (req_ready_o != 2'b00) begin
         if (exp_txn.size() == 0) begin
            chk("grant_unexpected", {62'd0, req_ready_o}, 64'd0);
         end else begin
            mon_t = exp_txn.pop_front();
            chk("grant", {62'd0, req_ready_o}, {62'd0, oh(mon_t.cli)});
            cur_t = mon_t;
            cur_cli = mon_t.cli;
         end
      end
      if (m_en_o) begin
         launch_cyc = cyc;
         chk("m_cmd", {56'd0, m_cmd_o}, {56'd0, cur_t.cmd});
         chk("m_addr", {56'd0, m_addr_o}, {56'd0, cur_t.addr});
         chk("m_num", {57'd0, m_num_o}, 64'(cur_t.len));
         chk("m_wdata_first", {56'd0, m_wdata_o}, (cur_t.len == 0) ? 64'd0 : {56'd0, cur_t.wd0});
      end
      if (rd_valid_o != 2'b00) begin
         rd_seen++;
         if (exp_rd.size() == 0) begin
            chk("rd_unexpected", {62'd0, rd_valid_o}, 64'd0);
         end else begin
            mon_r = exp_rd.pop_front();
            chk("rd_valid", {62'd0, rd_valid_o}, {62'd0, oh(mon_r.cli)});
            chk("rd_data", {56'd0, rd_data_o}, {56'd0, mon_r.data});
            chk("rd_latency", 64'(cyc - last_rdone_cyc), 64'd1);
         end
      end
      if (done_o != 2'b00) begin
         if (exp_done.size() == 0) begin
            chk("done_unexpected", {62'd0, done_o}, 64'd0);
         end else begin
            mon_d = exp_done.pop_front();
            chk("done_err_busy", {60'd0, done_o, err_o, busy_o}, {60'd0, oh(mon_d.cli), mon_d.err, 1'b1});
            if (mon_d.dly >= 0) chk("timeout_cycles", 64'(cyc - launch_cyc), 64'(mon_d.dly));
         end
      end
   end

   task automatic set_req(input int c, input logic [7:0] cmd, input logic [7:0] addr, input int len);
      if (c == 0) begin
         req_cmd_i[7:0] = cmd;  req_addr_i[7:0] = addr;  req_len_i[6:0] = 7'(len);
      end else begin
         req_cmd_i[15:8] = cmd; req_addr_i[15:8] = addr; req_len_i[13:7] = 7'(len);
      end
   endtask

   task automatic setup(input int c, input logic [7:0] cmd, input logic [7:0] addr,
                        input int len, input logic [31:0] w);
      set_req(c, cmd, addr, len);
      for (int j = 0; j < len; j++) begin
         if (c == 0) begin
            wfifo0.push_back(w[8*j +: 8]); expwd0.push_back(w[8*j +: 8]);
         end else begin
            wfifo1.push_back(w[8*j +: 8]); expwd1.push_back(w[8*j +: 8]);
         end
         exp_rd.push_back('{cli: c, data: 8'h42 + 8'(j)});
      end
      exp_txn.push_back('{cli: c, cmd: cmd, addr: addr, len: len, wd0: w[7:0]});
      exp_done.push_back('{cli: c, err: 1'b0, dly: -1});
   endtask

   task automatic run_reqs(input logic [1:0] mask);
      logic [1:0] r;
      req_valid_i = req_valid_i | mask;
      for (int i = 0; i < 1000 && req_valid_i != 2'b00; i++) begin
         @(negedge clk_i);
         r = req_ready_o;
         @(posedge clk_i);
         #1;
         req_valid_i = req_valid_i & ~r;
      end
      chk("request_accepted", {62'd0, req_valid_i}, 64'd0);
      req_valid_i = 2'b00;
   endtask

   task automatic wait_idle(input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_i);
         if (exp_txn.size() == 0 && exp_rd.size() == 0 && exp_done.size() == 0 && !busy_o && m_csn_i)
            ok = 1'b1;
      end
      chk("wait_idle_in_budget", 64'(ok), 64'd1);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_i = 1'b1;
      req_valid_i = 2'b00;
      req_cmd_i = 16'h0000;
      req_addr_i = 16'h0000;
      req_len_i = 14'd0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_outputs", all_outs(), 64'd0);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Simultaneous requests from a fresh pointer: client 0 then client 1.
      setup(0, 8'h0B, 8'h20, 1, 32'h0000_0011);
      setup(1, 8'h02, 8'h30, 1, 32'h0000_0022);
      run_reqs(2'b11);
      wait_idle(2000);

      // Basic read/write transaction, len 2.
      setup(0, 8'h03, 8'h10, 2, 32'h0000_5AA5);
      run_reqs(2'b01);
      wait_idle(2000);

      // Client 0 won last, so a tie now goes to client 1 first.
      setup(1, 8'h06, 8'h31, 1, 32'h0000_0033);
      setup(0, 8'h07, 8'h21, 1, 32'h0000_0044);
      run_reqs(2'b11);
      wait_idle(2000);

      // Zero-length: no pops, no reads, wdata forced to 0 despite a non-zero FIFO head.
      wfifo1.push_back(8'h77);
      setup(1, 8'h05, 8'h00, 0, 32'h0000_0000);
      run_reqs(2'b10);
      wait_idle(2000);
      chk("len0_no_pop", 64'(wfifo1.size()), 64'd1);
      wfifo1.delete();

      // Four data bytes: readback 0x42..0x45.
      setup(0, 8'h3B, 8'h40, 4, 32'h0403_0201);
      run_reqs(2'b01);
      wait_idle(2000);

      // Timeout with chip select stuck low.
      hang = 1'b1;
      set_req(1, 8'h0C, 8'h0D, 3);
      wfifo1.push_back(8'hB1); wfifo1.push_back(8'hB2); wfifo1.push_back(8'hB3);
      exp_txn.push_back('{cli: 1, cmd: 8'h0C, addr: 8'h0D, len: 3, wd0: 8'hB1});
      exp_done.push_back('{cli: 1, err: 1'b1, dly: TMO});
      run_reqs(2'b10);
      for (int i = 0; i < TMO + 100 && exp_done.size() != 0; i++) @(negedge clk_i);
      chk("timeout_done_seen", 64'(exp_done.size()), 64'd0);
      chk("tmo_no_pop", 64'(wfifo1.size()), 64'd3);
      wfifo1.delete();
      exp_done.delete();
      @(posedge clk_i);
      #1;
      // A new request must wait while the master is still selected.
      set_req(0, 8'hA1, 8'h00, 0);
      req_valid_i = 2'b01;
      repeat (20) @(posedge clk_i);
      #1;
      chk("held_off_while_csn_low", {62'd0, busy_o, m_en_o}, 64'd0);
      setup(0, 8'hA1, 8'h00, 0, 32'h0000_0000);
      hang = 1'b0;
      run_reqs(2'b01);
      wait_idle(2000);

      // Reset during data byte 1, then a fresh transaction.
      set_req(0, 8'h0A, 8'h55, 4);
      for (int j = 0; j < 4; j++) begin
         wfifo0.push_back(8'hC0 + 8'(j));
         expwd0.push_back(8'hC0 + 8'(j));
      end
      exp_txn.push_back('{cli: 0, cmd: 8'h0A, addr: 8'h55, len: 4, wd0: 8'hC0});
      exp_rd.push_back('{cli: 0, data: 8'h42});
      base = rd_seen;
      run_reqs(2'b01);
      for (int i = 0; i < 500 && rd_seen == base; i++) @(negedge clk_i);
      chk("first_byte_before_reset", 64'(rd_seen - base), 64'd1);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      aborted = 1'b1;
      @(posedge clk_i);
      #1;
      chk("reset_mid_outputs", all_outs(), 64'd0);
      rst_i = 1'b0;
      expwd0.delete();
      wfifo0.delete();
      wait_idle(2000);
      aborted = 1'b0;
      setup(1, 8'h9F, 8'h01, 1, 32'h0000_003C);
      run_reqs(2'b10);
      wait_idle(2000);

      chk("leftover_expectations",
          64'(exp_txn.size() + exp_rd.size() + exp_done.size() + expwd0.size() + expwd1.size()), 64'd0);
      chk("leftover_fifo", 64'(wfifo0.size() + wfifo1.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
